// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB, drives datapath enables and ALU
// controls combinationally from state/opcode/funct/zero, and counts retired instructions.
module mc_ctrl_unit #(
  parameter int unsigned CNT_W   = 32,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             IRWre,
  output logic             RegWre,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [2:0]       ALUOp,
  output logic             mRD,
  output logic             mWR,
  output logic             DBDataSrc,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpJal  = 6'b000011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;

  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_r, is_jr, r_alu, is_branch, is_mem, to_exe;
  logic pc_wre, ir_wre, reg_wre, m_rd, m_wr;

  always_comb begin
    is_r      = (opcode == OpR);
    is_jr     = is_r && (funct == FnJr);
    r_alu     = is_r && ((funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                         (funct == FnOr) || (funct == FnSlt));
    is_branch = (opcode == OpBeq) || (opcode == OpBne);
    is_mem    = (opcode == OpLw) || (opcode == OpSw);
    to_exe    = r_alu || is_branch || is_mem || (opcode == OpAddi) || (opcode == OpOri);
  end

  // ALU-side controls depend only on the instruction, so they hold across EXE/MEM/WB.
  always_comb begin
    ALUSrcB   = is_mem || (opcode == OpAddi) || (opcode == OpOri);
    ExtSel    = (opcode != OpOri);
    DBDataSrc = (opcode == OpLw);
    if (opcode == OpJal)  RegDst = 2'b00;
    else if (is_r)        RegDst = 2'b10;
    else                  RegDst = 2'b01;
    ALUOp = 3'b000;
    if (is_branch)              ALUOp = 3'b001;
    else if (opcode == OpOri)   ALUOp = 3'b011;
    else if (is_r) begin
      case (funct)
        FnSub:   ALUOp = 3'b001;
        FnAnd:   ALUOp = 3'b010;
        FnOr:    ALUOp = 3'b011;
        FnSlt:   ALUOp = 3'b100;
        default: ALUOp = 3'b000;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_wre    = 1'b0;
    PCSrc     = 2'b00;
    ir_wre    = 1'b0;
    reg_wre   = 1'b0;
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    WrRegDSrc = 1'b0;
    case (state_q)
      StIf: begin
        ir_wre  = 1'b1;
        state_d = StId;
      end
      StId: begin
        state_d = StIf;
        if (opcode == HALT_OP) begin
          state_d = StHalt;
        end else if (opcode == OpJ) begin
          pc_wre = 1'b1;
          PCSrc  = 2'b11;
        end else if (opcode == OpJal) begin
          pc_wre  = 1'b1;
          PCSrc   = 2'b11;
          reg_wre = 1'b1;
        end else if (is_jr) begin
          pc_wre = 1'b1;
          PCSrc  = 2'b10;
        end else if (to_exe) begin
          state_d = StExe;
        end else begin
          pc_wre = 1'b1;
        end
      end
      StExe: begin
        if (is_branch) begin
          pc_wre  = 1'b1;
          PCSrc   = ((opcode == OpBeq) == zero) ? 2'b01 : 2'b00;
          state_d = StIf;
        end else if (is_mem) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (opcode == OpLw) begin
          m_rd    = 1'b1;
          state_d = StWb;
        end else begin
          m_wr    = 1'b1;
          pc_wre  = 1'b1;
          state_d = StIf;
        end
      end
      StWb: begin
        reg_wre   = 1'b1;
        WrRegDSrc = 1'b1;
        pc_wre    = 1'b1;
        state_d   = StIf;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  // Write strobes are squashed while reset is held so an aborted instruction leaves no trace.
  always_comb begin
    PCWre  = pc_wre  & RST;
    IRWre  = ir_wre  & RST;
    RegWre = reg_wre & RST;
    mRD    = m_rd    & RST;
    mWR    = m_wr    & RST;
    cnt_d  = PCWre ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == StHalt);
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: per-instruction vector table plus hand sequences for
// reset, reset-during-MEM and HALT; per-cycle expectations flow through a scoreboard queue.
module tb_mc_ctrl_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc, halted;
  logic [1:0]  PCSrc, RegDst;
  logic [2:0]  ALUOp, state;
  logic [31:0] instr_cnt;

  mc_ctrl_unit #(.CNT_W(32), .HALT_OP(6'b111111)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state), .halted(halted),
    .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  typedef enum int {KJmp, KBr, KWb, KSw, KLw} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    kind_e      kind;
    logic [1:0] pcsrc;
    logic       regw;
    logic [1:0] regdst;
    logic       wrsrc;
    logic       dbsrc;
    logic       alu_chk;
    logic [2:0] aluop;
    logic       alusrcb;
    logic       ext_chk;
    logic       ext;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic        pcwre, irwre, regwre, mrd, mwr, hlt;
    logic        chk_pcsrc;
    logic [1:0]  pcsrc;
    logic        chk_wb;
    logic [1:0]  regdst;
    logic        wrsrc, dbsrc;
    logic        chk_alu;
    logic [2:0]  aluop;
    logic        alusrcb;
    logic        chk_ext, ext;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[18];
  int          checks = 0;
  int          errors = 0;
  int          tag = 0;
  logic [31:0] exp_cnt = 0;

  function automatic int kind_len(kind_e k);
    case (k)
      KJmp:    return 2;
      KBr:     return 3;
      KLw:     return 5;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] kind_st(kind_e k, int i);
    case (i)
      0:       return 3'd0;
      1:       return 3'd1;
      2:       return 3'd2;
      3:       return (k == KWb) ? 3'd4 : 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s (test %0d) got %0h expected %0h", nm, tag, act, expv);
    end
  endtask

  function automatic exp_t idle_exp(logic [2:0] st);
    exp_t e;
    e = '{default: '0};
    e.st  = st;
    e.hlt = (st == 3'd5);
    return e;
  endfunction

  task automatic do_cycle(input exp_t e);
    exp_t q;
    sb.push_back(e);
    @(negedge CLK);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty (test %0d)", tag);
    end else begin
      q = sb.pop_front();
      chk("state",  32'(state),  32'(q.st));
      chk("PCWre",  32'(PCWre),  32'(q.pcwre));
      chk("IRWre",  32'(IRWre),  32'(q.irwre));
      chk("RegWre", 32'(RegWre), 32'(q.regwre));
      chk("mRD",    32'(mRD),    32'(q.mrd));
      chk("mWR",    32'(mWR),    32'(q.mwr));
      chk("halted", 32'(halted), 32'(q.hlt));
      if (q.chk_pcsrc) chk("PCSrc", 32'(PCSrc), 32'(q.pcsrc));
      if (q.chk_wb) begin
        chk("RegDst",    32'(RegDst),    32'(q.regdst));
        chk("WrRegDSrc", 32'(WrRegDSrc), 32'(q.wrsrc));
        chk("DBDataSrc", 32'(DBDataSrc), 32'(q.dbsrc));
      end
      if (q.chk_alu) begin
        chk("ALUOp",   32'(ALUOp),   32'(q.aluop));
        chk("ALUSrcB", 32'(ALUSrcB), 32'(q.alusrcb));
      end
      if (q.chk_ext) chk("ExtSel", 32'(ExtSel), 32'(q.ext));
      if (q.chk_cnt) chk("instr_cnt", instr_cnt, q.cnt);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int n_cycles);
    exp_t e;
    int   len;
    logic last;
    opcode = v.op;
    funct  = v.fn;
    zero   = v.z;
    len    = kind_len(v.kind);
    for (int i = 0; i < n_cycles; i++) begin
      e         = idle_exp(kind_st(v.kind, i));
      last      = (i == len - 1);
      e.pcwre   = last;
      e.irwre   = (i == 0);
      e.regwre  = last && v.regw;
      e.mrd     = (e.st == 3'd3) && (v.kind == KLw);
      e.mwr     = (e.st == 3'd3) && (v.kind == KSw);
      e.chk_pcsrc = last;
      e.pcsrc   = v.pcsrc;
      e.chk_wb  = last && v.regw;
      e.regdst  = v.regdst;
      e.wrsrc   = v.wrsrc;
      e.dbsrc   = v.dbsrc;
      e.chk_alu = v.alu_chk && (e.st >= 3'd2);
      e.aluop   = v.aluop;
      e.alusrcb = v.alusrcb;
      e.chk_ext = v.ext_chk && (e.st >= 3'd2);
      e.ext     = v.ext;
      e.chk_cnt = (i == 0);
      e.cnt     = exp_cnt;
      do_cycle(e);
    end
    if (n_cycles == len) exp_cnt = exp_cnt + 1;
  endtask

  initial begin
    exp_t e;

    vecs[0]  = '{6'b001000, 6'b000000, 1'b0, KWb,  2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{6'b100011, 6'b000000, 1'b0, KLw,  2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{6'b000100, 6'b000000, 1'b1, KBr,  2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{6'b000100, 6'b000000, 1'b0, KBr,  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'b000101, 6'b000000, 1'b0, KBr,  2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'b000101, 6'b000000, 1'b1, KBr,  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'b000011, 6'b000000, 1'b0, KJmp, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'b000010, 6'b000000, 1'b0, KJmp, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'b000000, 6'b001000, 1'b0, KJmp, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'b010101, 6'b000000, 1'b0, KJmp, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{6'b000000, 6'b111111, 1'b0, KJmp, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{6'b000000, 6'b100000, 1'b0, KWb,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{6'b000000, 6'b100010, 1'b0, KWb,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{6'b000000, 6'b100100, 1'b0, KWb,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{6'b000000, 6'b100101, 1'b0, KWb,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{6'b000000, 6'b101010, 1'b0, KWb,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{6'b001101, 6'b000000, 1'b0, KWb,  2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{6'b101011, 6'b000000, 1'b0, KSw,  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1};

    // Reset for two edges with an instruction already on the bus: strobes must stay low.
    RST    = 1'b0;
    opcode = 6'b001000;
    @(posedge CLK);
    #1;
    tag = 100;
    for (int i = 0; i < 2; i++) begin
      e         = idle_exp(3'd0);
      e.chk_cnt = 1'b1;
      e.cnt     = 32'd0;
      if (i == 1) begin
        sb.push_back(e);
        @(negedge CLK);
        e = sb.pop_front();
        chk("rst_state", 32'(state), 32'(e.st));
        chk("rst_IRWre", 32'(IRWre), 32'(e.irwre));
        chk("rst_cnt",   instr_cnt,  e.cnt);
        @(posedge CLK);
        #1;
      end else begin
        do_cycle(e);
      end
    end
    RST     = 1'b1;
    exp_cnt = 0;

    for (int k = 0; k < 18; k++) begin
      tag = k;
      run_vec(vecs[k], kind_len(vecs[k].kind));
    end

    // sw aborted by reset in MEM: no write, no PC strobe, counter cleared.
    tag = 200;
    run_vec(vecs[17], 3);
    RST = 1'b0;
    do_cycle(idle_exp(3'd3));
    RST     = 1'b1;
    exp_cnt = 0;
    run_vec(vecs[7], 2);

    // HALT: parks with everything idle and the counter frozen until reset.
    tag    = 300;
    opcode = 6'b111111;
    funct  = 6'b000000;
    e         = idle_exp(3'd0);
    e.irwre   = 1'b1;
    e.chk_cnt = 1'b1;
    e.cnt     = exp_cnt;
    do_cycle(e);
    e       = idle_exp(3'd1);
    do_cycle(e);
    for (int i = 0; i < 10; i++) begin
      e         = idle_exp(3'd5);
      e.chk_cnt = 1'b1;
      e.cnt     = exp_cnt;
      do_cycle(e);
    end
    RST = 1'b0;
    do_cycle(idle_exp(3'd5));
    RST     = 1'b1;
    exp_cnt = 0;
    tag     = 301;
    run_vec(vecs[9], 2);
    run_vec(vecs[1], 5);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
